// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO for the transaction layer.
// Wrap-bit pointers give unambiguous full/empty. Occupancy is registered and all
// status flags are decoded from it. Thresholds can be reloaded at runtime, a flush
// clears the contents, sticky overflow/underflow errors are kept, and an optional
// first-word-fall-through read port is available.
module fifo_param #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 10,
    parameter int PTR_SIZE = $clog2(DEPTH),
    parameter int FWFT     = 0,
    parameter int AE_RST   = 2,
    parameter int AF_RST   = DEPTH - 2
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic [WIDTH-1:0]    data_in,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic                flush,
    input  logic                init,
    input  logic                clr_err,
    input  logic [PTR_SIZE:0]   ae_thr_in,
    input  logic [PTR_SIZE:0]   af_thr_in,
    output logic [WIDTH-1:0]    data_out,
    output logic                rd_valid,
    output logic [PTR_SIZE:0]   count,
    output logic                empty_flag,
    output logic                full_flag,
    output logic                almost_empty_flag,
    output logic                almost_full_flag,
    output logic                overflow_err,
    output logic                underflow_err
);

    // Constants sized to the pointer/count width so every compare is width-matched.
    localparam logic [PTR_SIZE:0] DEPTH_V = (PTR_SIZE+1)'(DEPTH);
    localparam logic [PTR_SIZE:0] AE_INIT = (PTR_SIZE+1)'(AE_RST);
    localparam logic [PTR_SIZE:0] AF_INIT = (PTR_SIZE+1)'(AF_RST);
    localparam logic [PTR_SIZE:0] PTR_ONE = (PTR_SIZE+1)'(1);

    // Storage; deliberately not reset.
    logic [WIDTH-1:0]    mem_q [DEPTH];

    // Pointers carry one extra wrap bit above the memory index.
    logic [PTR_SIZE:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_SIZE:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_SIZE:0]   count_q, count_d;

    // Runtime-programmable thresholds.
    logic [PTR_SIZE:0]   ae_thr_q, ae_thr_d;
    logic [PTR_SIZE:0]   af_thr_q, af_thr_d;

    // Sticky error flags.
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;

    logic [PTR_SIZE-1:0] wr_idx;
    logic [PTR_SIZE-1:0] rd_idx;
    logic                empty;
    logic                full;
    logic                pop_ok;
    logic                push_ok;
    logic                do_push;
    logic                do_pop;

    assign wr_idx = wr_ptr_q[PTR_SIZE-1:0];
    assign rd_idx = rd_ptr_q[PTR_SIZE-1:0];

    // Status comes from the registered occupancy, so flags never glitch.
    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_V);

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside a pop.
    assign pop_ok  = rd_en & ~empty;
    assign push_ok = wr_en & (~full | pop_ok);

    // Flush wins over any push/pop requested in the same cycle.
    assign do_push = push_ok & ~flush;
    assign do_pop  = pop_ok & ~flush;

    assign count             = count_q;
    assign empty_flag        = empty;
    assign full_flag         = full;
    assign almost_empty_flag = (count_q <= ae_thr_q);
    assign almost_full_flag  = (count_q >= af_thr_q);
    assign overflow_err      = ovf_q;
    assign underflow_err     = udf_q;

    // Pointer advance, flush clear, and occupancy derived from the next pointers.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
        count_d = wr_ptr_d - rd_ptr_d;
    end

    // Threshold reload with saturation at DEPTH; a larger value could never be reached anyway.
    always_comb begin
        ae_thr_d = ae_thr_q;
        af_thr_d = af_thr_q;
        if (init) begin
            ae_thr_d = (ae_thr_in > DEPTH_V) ? DEPTH_V : ae_thr_in;
            af_thr_d = (af_thr_in > DEPTH_V) ? DEPTH_V : af_thr_in;
        end
    end

    // Sticky errors: a new error in the same cycle as clr_err keeps the flag set.
    always_comb begin
        ovf_d = ovf_q & ~clr_err;
        udf_d = udf_q & ~clr_err;
        if (!flush && wr_en && !push_ok) begin
            ovf_d = 1'b1;
        end
        if (!flush && rd_en && !pop_ok) begin
            udf_d = 1'b1;
        end
    end

    // Control state register bank with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ae_thr_q <= AE_INIT;
            af_thr_q <= AF_INIT;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ae_thr_q <= ae_thr_d;
            af_thr_q <= af_thr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Memory write port.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Show-ahead: the head word is always presented; a pop consumes it.
            assign data_out = mem_q[rd_idx];
            assign rd_valid = ~empty;
        end else begin : g_registered
            logic [WIDTH-1:0] data_out_q;
            logic             rd_valid_q;

            // Registered read: capture the head on a pop and flag it valid for one cycle.
            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    data_out_q <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= do_pop;
                    if (do_pop) begin
                        data_out_q <= mem_q[rd_idx];
                    end
                end
            end

            assign data_out = data_out_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed bench for fifo_param. Two instances share every input,
// one with a registered read port and one in show-ahead mode, so their contents
// and flags track each other while their read ports are checked separately.
module tb_fifo_param;

    localparam int DEPTH = 8;
    localparam int WIDTH = 10;
    localparam int PW    = 4;

    logic             clk = 1'b0;
    logic             reset_L;
    logic [WIDTH-1:0] data_in;
    logic             wr_en;
    logic             rd_en;
    logic             flush;
    logic             init;
    logic             clr_err;
    logic [PW-1:0]    ae_thr_in;
    logic [PW-1:0]    af_thr_in;

    logic [WIDTH-1:0] dataOut0, dataOut1;
    logic             rdValid0, rdValid1;
    logic [PW-1:0]    count0, count1;
    logic             empty0, empty1, full0, full1;
    logic             ae0, ae1, af0, af1;
    logic             ovf0, ovf1, udf0, udf1;

    int checks = 0;
    int errors = 0;
    int thrAe  = 2;
    int thrAf  = 6;
    logic [WIDTH-1:0] fifoModel[$];

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    fifo_param #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(0)) dutReg (
        .clk(clk), .reset_L(reset_L), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .flush(flush), .init(init), .clr_err(clr_err), .ae_thr_in(ae_thr_in), .af_thr_in(af_thr_in),
        .data_out(dataOut0), .rd_valid(rdValid0), .count(count0), .empty_flag(empty0),
        .full_flag(full0), .almost_empty_flag(ae0), .almost_full_flag(af0),
        .overflow_err(ovf0), .underflow_err(udf0)
    );

    fifo_param #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(1)) dutFwft (
        .clk(clk), .reset_L(reset_L), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .flush(flush), .init(init), .clr_err(clr_err), .ae_thr_in(ae_thr_in), .af_thr_in(af_thr_in),
        .data_out(dataOut1), .rd_valid(rdValid1), .count(count1), .empty_flag(empty1),
        .full_flag(full1), .almost_empty_flag(ae1), .almost_full_flag(af1),
        .overflow_err(ovf1), .underflow_err(udf1)
    );

    // Drive one cycle of requests, let the edge pass, then sample 1 unit after it.
    task automatic applyStimulus(input logic w, input logic r, input logic [WIDTH-1:0] d,
                                 input logic fl, input logic ini, input logic ce);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        flush   = fl;
        init    = ini;
        clr_err = ce;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        flush   = 1'b0;
        init    = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Occupancy and every flag of the registered instance, plus the shadow instance's count.
    task automatic checkState(input string tag, input int expCount);
        checkOutput({tag, ".count"}, count0, expCount);
        checkOutput({tag, ".empty"}, empty0, expCount == 0);
        checkOutput({tag, ".full"}, full0, expCount == DEPTH);
        checkOutput({tag, ".almostEmpty"}, ae0, expCount <= thrAe);
        checkOutput({tag, ".almostFull"}, af0, expCount >= thrAf);
        checkOutput({tag, ".fwftCount"}, count1, expCount);
    endtask

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        logic [WIDTH-1:0] expWord;
        logic             doPop;

        reset_L   = 1'b0;
        data_in   = '0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        flush     = 1'b0;
        init      = 1'b0;
        clr_err   = 1'b0;
        ae_thr_in = '0;
        af_thr_in = '0;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset values.
        checkState("reset", 0);
        checkOutput("reset.dataOut", dataOut0, 0);
        checkOutput("reset.rdValid", rdValid0, 0);
        checkOutput("reset.fwftRdValid", rdValid1, 0);
        checkOutput("reset.ovf", ovf0, 0);
        checkOutput("reset.udf", udf0, 0);
        reset_L = 1'b1;

        // Test 1: fill with 0x001..0x008, then drain in order.
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1'b1, 1'b0, WIDTH'(i), 1'b0, 1'b0, 1'b0);
            checkState($sformatf("t1.push%0d", i), i);
            checkOutput($sformatf("t1.fwftHead%0d", i), dataOut1, 1);
            checkOutput($sformatf("t1.fwftValid%0d", i), rdValid1, 1);
        end
        for (int i = 1; i <= DEPTH; i++) begin
            checkOutput($sformatf("t1.fwftShow%0d", i), dataOut1, i);
            applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("t1.pop%0d", i), dataOut0, i);
            checkOutput($sformatf("t1.popValid%0d", i), rdValid0, 1);
            checkState($sformatf("t1.pop%0d", i), DEPTH - i);
        end
        checkOutput("t1.fwftEmptyValid", rdValid1, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("t1.idleValid", rdValid0, 0);
        checkOutput("t1.idleHold", dataOut0, 8);

        // Test 2: overflow on a full FIFO, sticky against a same-cycle clear.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1'b0, WIDTH'(10'h011 + i), 1'b0, 1'b0, 1'b0);
        end
        checkState("t2.full", 8);
        applyStimulus(1'b1, 1'b0, 10'h3FF, 1'b0, 1'b0, 1'b0);
        checkOutput("t2.ovf", ovf0, 1);
        checkOutput("t2.fwftOvf", ovf1, 1);
        checkState("t2.afterOvf", 8);
        applyStimulus(1'b1, 1'b0, 10'h3FE, 1'b0, 1'b0, 1'b1);
        checkOutput("t2.ovfSetWins", ovf0, 1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("t2.ovfCleared", ovf0, 0);

        // Test 3: push and pop together while full.
        checkOutput("t3.fwftHeadBefore", dataOut1, 10'h011);
        applyStimulus(1'b1, 1'b1, 10'h020, 1'b0, 1'b0, 1'b0);
        checkState("t3.both", 8);
        checkOutput("t3.head", dataOut0, 10'h011);
        checkOutput("t3.headValid", rdValid0, 1);
        checkOutput("t3.noOvf", ovf0, 0);
        checkOutput("t3.fwftHeadAfter", dataOut1, 10'h012);
        for (int i = 0; i < DEPTH; i++) begin
            expWord = (i < 7) ? WIDTH'(10'h012 + i) : 10'h020;
            applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("t3.drain%0d", i), dataOut0, expWord);
        end
        checkState("t3.empty", 0);

        // Test 4: underflow on empty, then pop+push on empty.
        applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("t4.udf", udf0, 1);
        checkOutput("t4.fwftUdf", udf1, 1);
        checkOutput("t4.noValid", rdValid0, 0);
        checkOutput("t4.fwftNoValid", rdValid1, 0);
        checkOutput("t4.holdData", dataOut0, 10'h020);
        applyStimulus(1'b1, 1'b1, 10'h055, 1'b0, 1'b0, 1'b0);
        checkState("t4.pushOnly", 1);
        checkOutput("t4.udfStill", udf0, 1);
        checkOutput("t4.noPopValid", rdValid0, 0);
        checkOutput("t4.fwftShow", dataOut1, 10'h055);
        checkOutput("t4.fwftValid", rdValid1, 1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("t4.udfCleared", udf0, 0);
        applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("t4.popWord", dataOut0, 10'h055);
        checkOutput("t4.noUdf", udf0, 0);
        checkState("t4.empty", 0);

        // Test 5: interleaved traffic so both pointers wrap twice.
        for (int k = 0; k < 20; k++) begin
            doPop   = (fifoModel.size() >= 3);
            expWord = '0;
            if (doPop) begin
                expWord = fifoModel.pop_front();
                checkOutput($sformatf("t5.fwftShow%0d", k), dataOut1, expWord);
            end
            fifoModel.push_back(WIDTH'(10'h100 + k));
            applyStimulus(1'b1, doPop, WIDTH'(10'h100 + k), 1'b0, 1'b0, 1'b0);
            if (doPop) begin
                checkOutput($sformatf("t5.pop%0d", k), dataOut0, expWord);
            end
            checkOutput($sformatf("t5.count%0d", k), count0, fifoModel.size());
            checkOutput($sformatf("t5.fullAndEmpty%0d", k), full0 & empty0, 0);
        end
        while (fifoModel.size() > 0) begin
            expWord = fifoModel.pop_front();
            applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
            checkOutput("t5.drain", dataOut0, expWord);
        end
        checkState("t5.empty", 0);

        // Test 6: programmed thresholds, flush, saturation on load.
        ae_thr_in = 4'd1;
        af_thr_in = 4'd3;
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        thrAe = 1;
        thrAf = 3;
        checkState("t6.init", 0);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 1'b0, WIDTH'(10'h0A0 + i), 1'b0, 1'b0, 1'b0);
            checkState($sformatf("t6.push%0d", i), i);
        end
        applyStimulus(1'b1, 1'b1, 10'h0AF, 1'b1, 1'b0, 1'b0);
        checkState("t6.flush", 0);
        checkOutput("t6.flushNoValid", rdValid0, 0);
        checkOutput("t6.flushNoOvf", ovf0, 0);
        checkOutput("t6.flushNoUdf", udf0, 0);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 1'b0, WIDTH'(10'h0B0 + i), 1'b0, 1'b0, 1'b0);
            checkState($sformatf("t6.kept%0d", i), i);
        end
        ae_thr_in = 4'd9;
        af_thr_in = 4'd12;
        applyStimulus(1'b1, 1'b0, 10'h0B4, 1'b0, 1'b1, 1'b0);
        thrAe = 8;
        thrAf = 8;
        checkState("t6.initWithPush", 4);
        for (int i = 5; i <= DEPTH; i++) begin
            applyStimulus(1'b1, 1'b0, WIDTH'(10'h0B0 + i), 1'b0, 1'b0, 1'b0);
        end
        checkState("t6.saturated", 8);
        applyStimulus(1'b1, 1'b0, 10'h3FF, 1'b0, 1'b0, 1'b0);
        checkOutput("t6.ovf", ovf0, 1);
        applyStimulus(1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b0);
        checkState("t6.flush2", 0);
        checkOutput("t6.ovfKept", ovf0, 1);

        // Reset asserted mid-burst: everything returns to reset values at once.
        applyStimulus(1'b1, 1'b0, 10'h0C1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 10'h0C2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst.prePop", dataOut0, 10'h0C1);
        reset_L = 1'b0;
        #1;
        thrAe = 2;
        thrAf = 6;
        checkState("rst.async", 0);
        checkOutput("rst.dataOut", dataOut0, 0);
        checkOutput("rst.rdValid", rdValid0, 0);
        checkOutput("rst.ovf", ovf0, 0);
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, 1'b0, WIDTH'(10'h0D0 + i), 1'b0, 1'b0, 1'b0);
            checkState($sformatf("rst.refill%0d", i), i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
